// File: rtl/grant_sequencer_if.sv
// Handshake bundle between the grant sequencer, its request sources and the
// external priority arbiter that turns req_vec into a one-hot gnt.
interface grant_sequencer_if;
  logic [7:0] req_set;
  logic [7:0] req_vec;
  logic [7:0] gnt;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       done;
  logic       err;
  logic [7:0] served_cnt;

  modport slave (
    input  req_set,
    input  gnt,
    output req_vec,
    output grant_valid,
    output grant_id,
    output done,
    output err,
    output served_cnt
  );

  modport master (
    output req_set,
    output gnt,
    input  req_vec,
    input  grant_valid,
    input  grant_id,
    input  done,
    input  err,
    input  served_cnt
  );
endinterface

// File: rtl/grant_sequencer.sv
// Accumulates per-client requests, accepts one arbiter grant at a time and
// serves the granted client for HOLD cycles followed by a one-cycle done.
module grant_sequencer #(
  parameter int unsigned HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  grant_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state_reg, state_next;
  logic [7:0] pending_reg, pending_next;
  logic [3:0] count_reg, count_next;
  logic [2:0] grant_id_reg, grant_id_next;
  logic [7:0] served_reg, served_next;
  logic [7:0] clr;
  logic       err_flag;

  logic       gnt_onehot;
  logic       gnt_covered;
  logic [2:0] gnt_enc;

  // Bit b of the binary index is the OR of every grant line whose index has bit b set.
  function automatic logic [7:0] enc_mask(input int b);
    logic [7:0] m;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      m[j] = ((j >> b) & 1) == 1;
    end
    return m;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_enc
      assign gnt_enc[gi] = |(bus.gnt & enc_mask(gi));
    end
    // A fresh request on a bit wins over the clear issued in the same cycle.
    for (gi = 0; gi < 8; gi++) begin : g_pending
      assign pending_next[gi] = bus.req_set[gi] | (pending_reg[gi] & ~clr[gi]);
    end
  endgenerate

  assign gnt_onehot  = (bus.gnt != 8'd0) && ((bus.gnt & (bus.gnt - 8'd1)) == 8'd0);
  assign gnt_covered = (bus.gnt & ~pending_reg) == 8'd0;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    grant_id_next = grant_id_reg;
    served_next   = served_reg;
    clr           = '0;
    err_flag      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg != 8'd0) begin
          if (gnt_onehot && gnt_covered) begin
            grant_id_next = gnt_enc;
            clr           = bus.gnt;
            count_next    = HOLD_LAST;
            state_next    = SERVE;
          end else begin
            err_flag = 1'b1;
          end
        end
      end
      SERVE: begin
        if (count_reg == 4'd0) begin
          served_next = served_reg + 8'd1;
          state_next  = DONE;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      count_reg    <= '0;
      grant_id_reg <= '0;
      served_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      count_reg    <= count_next;
      grant_id_reg <= grant_id_next;
      served_reg   <= served_next;
    end
  end

  // served_cnt steps on entry to DONE so it is already current while done is high.
  assign bus.req_vec     = pending_reg;
  assign bus.grant_valid = (state_reg == SERVE);
  assign bus.grant_id    = grant_id_reg;
  assign bus.done        = (state_reg == DONE);
  assign bus.err         = err_flag;
  assign bus.served_cnt  = served_reg;

  err_done_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.err && bus.done));

  grant_id_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.grant_valid && $past(bus.grant_valid)) |-> $stable(bus.grant_id));

endmodule

// File: tb/tb_grant_sequencer.sv
// Scoreboard bench for grant_sequencer: stimulus pushes expected done/err
// events, an independent monitor pops them as the DUT presents them.
module tb_grant_sequencer;

  localparam int HOLD = 4;

  typedef struct {
    bit         is_err;
    logic [2:0] id;
    logic [7:0] cnt;
    logic [7:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  grant_sequencer_if bus();

  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'd0;

  exp_t       exp_q[$];
  logic [7:0] exp_cnt = 8'd0;
  int         vectors = 0;
  int         miscompares = 0;
  int         done_seen = 0;
  int         cyc = 0;
  bit         tput_en = 1'b0;
  bit         have_prev = 1'b0;
  int         prev_done_cyc = 0;

  grant_sequencer #(.HOLD(HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Arbiter model: lowest set bit of req_vec, unless the bench overrides it.
  always_comb bus.gnt = force_en ? force_val : (bus.req_vec & (~bus.req_vec + 8'd1));

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting, got no event expected event", name);
  endtask

  task automatic expect_done(input logic [2:0] id);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.is_err = 1'b0; e.id = id; e.cnt = exp_cnt; e.vec = 8'd0;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [7:0] vec);
    exp_t e;
    e.is_err = 1'b1; e.id = 3'd0; e.cnt = 8'd0; e.vec = vec;
    exp_q.push_back(e);
  endtask

  // Drives req_set for one sampling edge; returns just after that edge.
  task automatic post(input logic [7:0] v);
    @(posedge clk); #1 bus.req_set = v;
    @(posedge clk); #1 bus.req_set = 8'd0;
  endtask

  task automatic wait_gv(input logic lvl, input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.grant_valid === lvl) return;
    end
    timeout_fail(name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.grant_valid === 1'b0 && bus.done === 1'b0) return;
    end
    timeout_fail(name);
  endtask

  // Monitor: tracks each service run and scores done/err against the queue.
  initial begin
    int         run_len;
    logic [2:0] run_id;
    exp_t       e;
    run_len = 0;
    run_id  = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0;
      end else begin
        if (bus.err === 1'b1 && bus.done === 1'b1) check("err_done_overlap", 8'd1, 8'd0);
        if (bus.grant_valid === 1'b1) begin
          if (run_len == 0) run_id = bus.grant_id;
          else if (bus.grant_id !== run_id) check("grant_id_stable", {5'd0, bus.grant_id}, {5'd0, run_id});
          run_len++;
        end
        if (bus.done === 1'b1) begin
          done_seen++;
          if (tput_en && have_prev) check("done_interval", 8'(cyc - prev_done_cyc), 8'(HOLD + 2));
          prev_done_cyc = cyc;
          have_prev = 1'b1;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 8'd1, 8'd0);
          end else begin
            e = exp_q.pop_front();
            check("done_kind", {7'd0, e.is_err}, 8'd0);
            check("served_id", {5'd0, run_id}, {5'd0, e.id});
            check("serve_len", 8'(run_len), 8'(HOLD));
            check("served_cnt", bus.served_cnt, e.cnt);
          end
          $display("done id=%0d len=%0d served_cnt=%0d", run_id, run_len, bus.served_cnt);
          run_len = 0;
        end
        if (bus.err === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_err", 8'd1, 8'd0);
          end else begin
            e = exp_q.pop_front();
            check("err_kind", {7'd0, e.is_err}, 8'd1);
            check("err_req_vec", bus.req_vec, e.vec);
          end
          $display("err req_vec=%0h gnt=%0h", bus.req_vec, bus.gnt);
        end
      end
    end
  end

  initial begin
    int done_base;
    bus.req_set = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_vec", bus.req_vec, 8'd0);
    check("rst_grant_valid", {7'd0, bus.grant_valid}, 8'd0);
    check("rst_grant_id", {5'd0, bus.grant_id}, 8'd0);
    check("rst_done", {7'd0, bus.done}, 8'd0);
    check("rst_err", {7'd0, bus.err}, 8'd0);
    check("rst_served_cnt", bus.served_cnt, 8'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single request for client 2
    expect_done(3'd2);
    post(8'h04);
    @(negedge clk);
    check("single_req_vec_E", bus.req_vec, 8'h04);
    check("single_gv_E", {7'd0, bus.grant_valid}, 8'd0);
    @(negedge clk);
    check("single_gv_E1", {7'd0, bus.grant_valid}, 8'd1);
    check("single_id_E1", {5'd0, bus.grant_id}, 8'd2);
    check("single_req_vec_E1", bus.req_vec, 8'h00);
    drain("single_drain");
    check("single_served_cnt", bus.served_cnt, 8'd1);

    // Priority order 0, 5, 7
    expect_done(3'd0); expect_done(3'd5); expect_done(3'd7);
    post(8'hA1);
    @(negedge clk); check("prio_req_vec_0", bus.req_vec, 8'hA1);
    @(negedge clk); check("prio_req_vec_1", bus.req_vec, 8'hA0);
    repeat (5) @(negedge clk); check("prio_req_vec_6", bus.req_vec, 8'hA0);
    @(negedge clk); check("prio_req_vec_7", bus.req_vec, 8'h80);
    repeat (6) @(negedge clk); check("prio_req_vec_13", bus.req_vec, 8'h00);
    drain("prio_drain");
    check("prio_served_cnt", bus.served_cnt, 8'd4);

    // Set/clear collision on client 3 in its acceptance cycle
    expect_done(3'd3); expect_done(3'd3);
    @(posedge clk); #1 bus.req_set = 8'h08;
    @(posedge clk); #1 bus.req_set = 8'h08;
    @(posedge clk); #1 bus.req_set = 8'h00;
    @(negedge clk);
    check("coll_req_vec", bus.req_vec, 8'h08);
    check("coll_gv", {7'd0, bus.grant_valid}, 8'd1);
    drain("coll_drain");
    check("coll_req_vec_end", bus.req_vec, 8'h00);

    // Illegal grants: multi-hot, then non-pending; ignored while pending is empty
    expect_err(8'h03); expect_err(8'h03);
    expect_done(3'd0); expect_done(3'd1);
    force_val = 8'h03;
    force_en  = 1'b1;
    post(8'h03);
    @(negedge clk);
    check("ill_req_vec_0", bus.req_vec, 8'h03);
    check("ill_gv_0", {7'd0, bus.grant_valid}, 8'd0);
    @(posedge clk); #1 force_val = 8'h10;
    @(negedge clk);
    check("ill_req_vec_1", bus.req_vec, 8'h03);
    check("ill_gv_1", {7'd0, bus.grant_valid}, 8'd0);
    @(posedge clk); #1 force_en = 1'b0;
    drain("ill_drain");
    check("ill_served_cnt", bus.served_cnt, 8'd8);

    // Reset during the second SERVE cycle of client 1
    post(8'h02);
    @(posedge clk);
    @(posedge clk); #2;
    check("abort_gv_before", {7'd0, bus.grant_valid}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("abort_req_vec", bus.req_vec, 8'd0);
    check("abort_gv", {7'd0, bus.grant_valid}, 8'd0);
    check("abort_grant_id", {5'd0, bus.grant_id}, 8'd0);
    check("abort_done", {7'd0, bus.done}, 8'd0);
    check("abort_err", {7'd0, bus.err}, 8'd0);
    check("abort_served_cnt", bus.served_cnt, 8'd0);
    exp_cnt = 8'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_vec_after", bus.req_vec, 8'd0);
    check("abort_done_after", {7'd0, bus.done}, 8'd0);
    check("abort_served_after", bus.served_cnt, 8'd0);

    // 256 back-to-back services: client 0 re-requests while being served
    done_base = done_seen;
    have_prev = 1'b0;
    tput_en   = 1'b1;
    for (int i = 0; i < 256; i++) expect_done(3'd0);
    post(8'h01);
    for (int i = 0; i < 256; i++) begin
      wait_gv(1'b1, "wrap_wait_serve");
      if (i < 255) post(8'h01);
      wait_gv(1'b0, "wrap_wait_done");
    end
    drain("wrap_drain");
    tput_en = 1'b0;
    check("wrap_served_cnt", bus.served_cnt, 8'd0);
    check("wrap_done_count", 8'(done_seen - done_base), 8'(256));
    check("wrap_done_count_hi", 8'((done_seen - done_base) >> 8), 8'd1);
    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
